uart_multiplier: RTL and testbench

- Standalone UART peripheral: receives two 8-bit unsigned operands on a serial line, multiplies them, and returns the 16-bit product on a serial line.
- Sits directly on board UART pins, with one clock domain and no host bus.
- Line format is 8N1, LSB first, idle high, at a compile-time baud rate.

---
 rtl/uart_multiplier.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_multiplier.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_multiplier.sv
// uart_multiplier: receives two 8-bit operands over an 8N1 UART line,
// multiplies them and sends back the 16-bit product, high byte first.
module uart_multiplier #(
  parameter int DesiredBaudRate = 9_600,
  parameter int ClockFrequency  = 12_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic tx_o
);

  localparam int CyclesPerBit = (ClockFrequency + DesiredBaudRate / 2) / DesiredBaudRate;
  localparam int CntW         = $clog2(CyclesPerBit);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t BitLast  = cnt_t'(CyclesPerBit - 1);
  localparam cnt_t HalfLast = cnt_t'(CyclesPerBit / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  // ---------------------------------------------------------------------------
  // RX synchronizer plus one extra stage for falling-edge detection
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // Bring rx_i into the clk_i domain; the line idles high so reset to 1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value of
      // its neighbour, which is what turns this chain into a real shift register.
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_e  rx_state_q, rx_state_d;
  cnt_t       rx_cnt_q, rx_cnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_valid_q, rx_valid_d;

  // RX next-state: mid-bit sampling timed from the detected start edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HalfLast) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        // Line already back high at mid start bit: treat as a glitch.
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BitLast) begin
        rx_cnt_d   = '0;
        rx_valid_d = rx_sync_q;  // low stop bit is a frame error: drop byte
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand sequencing and one-entry pending-product buffer
  // ---------------------------------------------------------------------------
  logic [7:0]  op_a_q;
  logic        expect_b_q;
  logic [15:0] pend_q;
  logic        pend_full_q;
  logic        pend_pop;
  logic        pend_push;

  // Push only when empty; a product arriving while full is dropped.
  assign pend_push = rx_valid_q && expect_b_q && !pend_full_q;

  // Latch A, then on B write A*B into the pending buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_q      <= '0;
      expect_b_q  <= 1'b0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      if (rx_valid_q) begin
        if (!expect_b_q) op_a_q <= rx_shift_q;
        expect_b_q <= !expect_b_q;
      end
      if (pend_push) begin
        pend_q      <= 16'(op_a_q) * 16'(rx_shift_q);
        pend_full_q <= 1'b1;
      end else if (pend_pop) begin
        pend_full_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  tx_state_e  tx_state_q, tx_state_d;
  cnt_t       tx_cnt_q, tx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] tx_low_q, tx_low_d;
  logic       tx_lo_byte_q, tx_lo_byte_d;
  logic       tx_q, tx_d;

  // TX next-state: the line level is computed here and registered below, so
  // each bit edge lands exactly CyclesPerBit cycles after the previous one.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q + 1'b1;
    tx_bit_d     = tx_bit_q;
    tx_shift_d   = tx_shift_q;
    tx_low_d     = tx_low_q;
    tx_lo_byte_d = tx_lo_byte_q;
    tx_d         = tx_q;
    pend_pop     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (pend_full_q) begin
          pend_pop     = 1'b1;
          tx_shift_d   = pend_q[15:8];
          tx_low_d     = pend_q[7:0];
          tx_lo_byte_d = 1'b0;
          tx_d         = 1'b0;
          tx_state_d   = TX_START;
        end
      end
      TX_START: if (tx_cnt_q == BitLast) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_d       = tx_shift_q[0];
        tx_state_d = TX_DATA;
      end
      TX_DATA: if (tx_cnt_q == BitLast) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) begin
          tx_d       = 1'b1;
          tx_state_d = TX_STOP;
        end else begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_d       = tx_shift_q[1];
          tx_bit_d   = tx_bit_q + 3'd1;
        end
      end
      TX_STOP: if (tx_cnt_q == BitLast) begin
        tx_cnt_d = '0;
        if (!tx_lo_byte_q) begin
          // Low byte starts straight after the high byte's stop bit.
          tx_shift_d   = tx_low_q;
          tx_lo_byte_d = 1'b1;
          tx_d         = 1'b0;
          tx_state_d   = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // TX state register; tx_q resets high so the line idles at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_shift_q   <= '0;
      tx_low_q     <= '0;
      tx_lo_byte_q <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_shift_q   <= tx_shift_d;
      tx_low_q     <= tx_low_d;
      tx_lo_byte_q <= tx_lo_byte_d;
      tx_q         <= tx_d;
    end
  end

  assign tx_o = tx_q;

endmodule

// File: tb/tb_uart_multiplier.sv
// tb_uart_multiplier: drives serial operand bytes into uart_multiplier and
// checks every cycle of every transmitted frame against a product model.
module tb_uart_multiplier;

  // 50 clocks per bit keeps the run short while exercising the same logic.
  localparam int Baud = 240_000;
  localparam int Clk  = 12_000_000;
  localparam int CPB  = 50;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic rx_i   = 1'b1;
  logic tx_o;

  uart_multiplier #(
    .DesiredBaudRate(Baud),
    .ClockFrequency (Clk)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .rx_i  (rx_i),
    .tx_o  (tx_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected TX bytes in order; bit 8 marks a high byte (low byte must follow).
  logic [8:0] exp_q[$];
  // Bytes actually decoded from tx_o, compared against literal lists.
  logic [7:0] rx_log[$];
  // Operand model state.
  logic       have_a = 1'b0;
  logic [7:0] model_a = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Product model: pair up accepted bytes, queue high then low byte.
  task automatic model_byte(input logic [7:0] b);
    logic [15:0] p;
    if (!have_a) begin
      model_a = b;
      have_a  = 1'b1;
    end else begin
      p = 16'(model_a) * 16'(b);
      exp_q.push_back({1'b1, p[15:8]});
      exp_q.push_back({1'b0, p[7:0]});
      have_a = 1'b0;
    end
  endtask

  // Hold rx_i at v for n cycles; called at posedge+1.
  task automatic drive(input logic v, input int n);
    rx_i = v;
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int cpb);
    drive(1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(b[i], cpb);
    // Model updates as the stop bit begins, before the DUT samples it.
    if (stop_bit) model_byte(b);
    drive(stop_bit, cpb);
    if (!stop_bit) drive(1'b1, cpb);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b1, CPB);
  endtask

  // Wait (bounded) until every expected byte has started, then let it finish.
  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 60 * CPB) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
    drive(1'b1, 12 * CPB);
  endtask

  // Compare decoded bytes with a literal list packed MSB-first in v.
  task automatic check_log(input string name, input int n, input logic [63:0] v);
    check({name, "_count"}, rx_log.size(), n);
    for (int i = 0; i < n && i < rx_log.size(); i++)
      check($sformatf("%s_byte%0d", name, i), rx_log[i], v[8*(n-1-i) +: 8]);
    rx_log.delete();
  endtask

  // Compare process: each frame is checked cycle by cycle against its model.
  initial begin : tx_monitor
    logic [9:0] frame;
    logic [9:0] dec;
    logic [8:0] ent;
    logic       chain, aborted, bad, bad_val, mid;
    forever begin
      @(negedge clk_i);
      chain = rst_ni && (tx_o === 1'b0);
      while (chain) begin
        check("frame_expected", exp_q.size() != 0, 1);
        ent = 9'h000;
        if (exp_q.size() != 0) ent = exp_q.pop_front();
        frame   = {1'b1, ent[7:0], 1'b0};
        dec     = '0;
        aborted = 1'b0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          bad     = 1'b0;
          bad_val = 1'b0;
          mid     = 1'b0;
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk_i);
            if (!rst_ni) begin
              aborted = 1'b1;
              break;
            end
            if (c == CPB / 2) mid = tx_o;
            if (tx_o !== frame[b] && !bad) begin
              bad     = 1'b1;
              bad_val = tx_o;
            end
          end
          if (!aborted) begin
            check($sformatf("tx_bit%0d", b), bad ? bad_val : mid, frame[b]);
            dec[b] = mid;
          end
        end
        chain = 1'b0;
        if (!aborted) begin
          rx_log.push_back(dec[8:1]);
          if (ent[8]) begin
            @(negedge clk_i);
            check("lo_no_gap", tx_o, 0);
            chain = rst_ni && (tx_o === 1'b0);
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (90_000) @(posedge clk_i);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : stimulus
    int lows;
    int t;

    // Reset and idle line.
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_tx", tx_o, 1);
    rst_ni = 1'b1;
    lows = 0;
    repeat (2 * CPB) begin
      @(posedge clk_i);
      #1;
      if (tx_o !== 1'b1) lows++;
    end
    check("idle_tx", lows, 0);

    // Basic: 3*5 = 15.
    send(8'h03); send(8'h05);
    drain("basic");
    check_log("basic", 2, 64'h000F);

    // Boundary operands.
    send(8'hFF); send(8'hFF);
    send(8'h10); send(8'h10);
    send(8'h00); send(8'h7B);
    drain("bound");
    check_log("bound", 6, 64'hFE01_0100_0000);

    // Back-to-back with no idle between frames.
    send(8'h02); send(8'h03); send(8'h04); send(8'h05);
    drain("b2b");
    check_log("b2b", 4, 64'h0006_0014);

    // Frame error on the first byte must not shift operand alignment.
    send_byte(8'h07, 1'b0, CPB);
    send(8'h07); send(8'h09);
    drain("ferr");
    check_log("ferr", 2, 64'h003F);

    // Short low glitch while idle is ignored.
    drive(1'b0, CPB / 5);
    drive(1'b1, 2 * CPB);
    send(8'h05); send(8'h06);
    drain("noise");
    check_log("noise", 2, 64'h001E);

    // Reset between operands forgets A.
    send(8'h11);
    drive(1'b1, CPB);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst_pulse_tx", tx_o, 1);
    rst_ni = 1'b1;
    have_a = 1'b0;
    send(8'h02); send(8'h08);
    drain("rst_op");
    check_log("rst_op", 2, 64'h0010);

    // Reset during the high byte: line goes high at once and stays there.
    send(8'h03); send(8'h05);
    t = 0;
    while (tx_o !== 1'b0 && t < 20 * CPB) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    check("rst_tx_started", tx_o, 0);
    repeat (3 * CPB) begin
      @(posedge clk_i);
      #1;
    end
    rst_ni = 1'b0;
    #1;
    check("rst_mid_tx", tx_o, 1);
    exp_q.delete();
    have_a = 1'b0;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    rst_ni = 1'b1;
    lows = 0;
    repeat (25 * CPB) begin
      @(posedge clk_i);
      #1;
      if (tx_o !== 1'b1) lows++;
    end
    check("no_bits_after_rst", lows, 0);
    check_log("rst_tx", 0, 64'h0);

    // Peer clocks 2% fast then 2% slow.
    send_byte(8'h0C, 1'b1, CPB - 1); send_byte(8'h0B, 1'b1, CPB - 1);
    send_byte(8'h0D, 1'b1, CPB + 1); send_byte(8'h0A, 1'b1, CPB + 1);
    drain("baud");
    check_log("baud", 4, 64'h0084_0082);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
